// File: rtl/sb_pattern_gen_param.sv
// Sideband clock-pattern generator for LTSM SBINIT: 1 ms send/gap bursts, tail words after RX detect.
// Optional SB_PATTERN_PROG_EN adds i_pattern, captured at sequence start and driven on o_pattern.
module sb_pattern_gen_param #(
  parameter int PATTERN_W     = 64,
  parameter int CYCLES_PER_MS = 100,
  parameter int TIMEOUT_MS    = 8,
  parameter int EXTRA_ITER    = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start_pattern_req,
  input  logic                             i_abort,
  input  logic                             i_rx_sb_pattern_samp_done,
  input  logic                             i_ser_done,
`ifdef SB_PATTERN_PROG_EN
  input  logic [PATTERN_W-1:0]             i_pattern,
`endif
  output logic [PATTERN_W-1:0]             o_pattern,
  output logic                             o_pattern_valid,
  output logic                             o_start_pattern_done,
  output logic                             o_pattern_time_out,
  output logic                             o_busy,
  output logic [$clog2(EXTRA_ITER+1)-1:0]  o_tail_cnt
);

  localparam int MSC_W  = $clog2(CYCLES_PER_MS);
  localparam int MSN_W  = $clog2(TIMEOUT_MS);
  localparam int TAIL_W = $clog2(EXTRA_ITER+1);
  localparam logic [MSC_W-1:0]     MS_LAST     = MSC_W'(CYCLES_PER_MS-1);
  localparam logic [MSN_W-1:0]     TOUT_LAST   = MSN_W'(TIMEOUT_MS-1);
  localparam logic [TAIL_W-1:0]    TAIL_LAST   = TAIL_W'(EXTRA_ITER);
  localparam logic [PATTERN_W-1:0] DEFAULT_PAT = {(PATTERN_W/2){2'b10}};

  typedef enum logic [2:0] {IDLE, SEND, GAP, TAIL, DONE, TOUT} state_t;

  state_t              state_reg, state_next;
  logic [MSC_W-1:0]    ms_cyc_reg, ms_cyc_next;
  logic [MSN_W-1:0]    ms_cnt_reg, ms_cnt_next;
  logic [TAIL_W-1:0]   tail_reg, tail_next;
  logic                samp_reg, samp_next;
  logic                valid_reg, valid_next;
  logic                req_d_reg;
  logic                req_edge, in_window, ms_wrap, ms_final;

  assign req_edge  = i_start_pattern_req & ~req_d_reg;
  assign in_window = (state_reg == SEND) || (state_reg == GAP);
  assign ms_wrap   = in_window && (ms_cyc_reg == MS_LAST);
  assign ms_final  = ms_wrap && (ms_cnt_reg == TOUT_LAST);

  always_comb begin
    state_next  = state_reg;
    ms_cyc_next = ms_cyc_reg;
    ms_cnt_next = ms_cnt_reg;
    tail_next   = tail_reg;
    samp_next   = samp_reg;
    valid_next  = 1'b0;

    if (in_window) begin
      if (ms_wrap) begin
        ms_cyc_next = '0;
        ms_cnt_next = ms_cnt_reg + 1'b1;
      end else begin
        ms_cyc_next = ms_cyc_reg + 1'b1;
      end
      if (i_rx_sb_pattern_samp_done) samp_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        ms_cyc_next = '0;
        ms_cnt_next = '0;
        if (req_edge) state_next = SEND;
      end
      SEND: begin
        valid_next = i_ser_done;
        // A detect arriving on the final wrap still beats the timeout.
        if (samp_reg || (ms_final && i_rx_sb_pattern_samp_done)) state_next = TAIL;
        else if (ms_final)                                        state_next = TOUT;
        else if (ms_wrap)                                         state_next = GAP;
      end
      GAP: begin
        if (samp_reg || i_rx_sb_pattern_samp_done) state_next = TAIL;
        else if (ms_final)                         state_next = TOUT;
        else if (ms_wrap)                          state_next = SEND;
      end
      TAIL: begin
        if (tail_reg == TAIL_LAST) begin
          state_next = DONE;
        end else if (i_ser_done) begin
          valid_next = 1'b1;
          tail_next  = tail_reg + 1'b1;
        end
      end
      DONE, TOUT: begin
        ms_cyc_next = '0;
        ms_cnt_next = '0;
        tail_next   = '0;
        samp_next   = 1'b0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (i_abort) begin
      state_next  = IDLE;
      ms_cyc_next = '0;
      ms_cnt_next = '0;
      tail_next   = '0;
      samp_next   = 1'b0;
      valid_next  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      ms_cyc_reg <= '0;
      ms_cnt_reg <= '0;
      tail_reg   <= '0;
      samp_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      req_d_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ms_cyc_reg <= ms_cyc_next;
      ms_cnt_reg <= ms_cnt_next;
      tail_reg   <= tail_next;
      samp_reg   <= samp_next;
      valid_reg  <= valid_next;
      req_d_reg  <= i_start_pattern_req;
    end
  end

`ifdef SB_PATTERN_PROG_EN
  logic [PATTERN_W-1:0] pattern_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      pattern_reg <= DEFAULT_PAT;
    else if ((state_reg == IDLE) && (state_next == SEND))
      pattern_reg <= i_pattern;
  end

  assign o_pattern = pattern_reg;
`else
  assign o_pattern = DEFAULT_PAT;
`endif

  // Abort masks the already-registered qualifiers in the same cycle.
  assign o_pattern_valid      = valid_reg & ~i_abort;
  assign o_start_pattern_done = (state_reg == DONE) & ~i_abort;
  assign o_pattern_time_out   = (state_reg == TOUT) & ~i_abort;
  assign o_busy               = (state_reg != IDLE);
  assign o_tail_cnt           = tail_reg;

endmodule

// File: tb/tb_sb_pattern_gen_param.sv
// Scoreboard bench for sb_pattern_gen_param (default parameters); expected events are queued
// by the stimulus and a negedge monitor pops one per valid/done/timeout the DUT presents.
module tb_sb_pattern_gen_param;

  localparam logic [63:0] DEF_PAT  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] PROG_PAT = 64'hDEAD_BEEF_0123_4567;
  localparam int EV_VALID = 0, EV_DONE = 1, EV_TOUT = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, abort = 1'b0, samp = 1'b0, ser = 1'b0;
  logic [63:0] pattern;
  logic        valid, done, tout, busy;
  logic [2:0]  tail_cnt;
`ifdef SB_PATTERN_PROG_EN
  logic [63:0] pat_in = 64'h0;
`endif

  int   cyc_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  logic [63:0] exp_pat;

  sb_pattern_gen_param dut (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_start_pattern_req       (req),
    .i_abort                   (abort),
    .i_rx_sb_pattern_samp_done (samp),
    .i_ser_done                (ser),
`ifdef SB_PATTERN_PROG_EN
    .i_pattern                 (pat_in),
`endif
    .o_pattern                 (pattern),
    .o_pattern_valid           (valid),
    .o_start_pattern_done      (done),
    .o_pattern_time_out        (tout),
    .o_busy                    (busy),
    .o_tail_cnt                (tail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc_cnt, act, req_v);
    end
  endtask

  task automatic take(input int kind, input logic [63:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d got=%h required=none", kind, cyc_cnt, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc_cnt || (kind == EV_VALID && e.data !== data)) begin
        failures++;
        $display("FAIL event got kind=%0d cyc=%0d data=%h required kind=%0d cyc=%0d data=%h",
                 kind, cyc_cnt, data, e.kind, e.cyc, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (valid) take(EV_VALID, pattern);
    if (done)  take(EV_DONE, 64'h0);
    if (tout)  take(EV_TOUT, 64'h0);
  end

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = exp_pat;
    exp_q.push_back(e);
  endtask

  task automatic push_valids(input int from_c, input int to_c);
    for (int c = from_c; c <= to_c; c++) push_ev(EV_VALID, c);
  endtask

  // Valids of the four SEND windows (ms0, ms2, ms4, ms6) of a full run.
  task automatic push_send_windows(input int k);
    for (int m = 0; m < 8; m += 2) push_valids(k + 2 + 100*m, k + 101 + 100*m);
  endtask

  task automatic goto(input int n);
    while (cyc_cnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_seq(output int k);
    req = 1'b0;
    @(posedge clk);
    #1;
`ifdef SB_PATTERN_PROG_EN
    pat_in = PROG_PAT;
`endif
    req = 1'b1;
    k = cyc_cnt;
  endtask

  task automatic mid_change(input int k);
    goto(k + 30);
`ifdef SB_PATTERN_PROG_EN
    pat_in = 64'h1111_2222_3333_4444;
`endif
  endtask

  task automatic expect_drained(input string name);
    chk(name, 64'(exp_q.size()), 64'h0);
    exp_q.delete();
  endtask

  initial begin
    int k;
`ifdef SB_PATTERN_PROG_EN
    exp_pat = PROG_PAT;
`else
    exp_pat = DEF_PAT;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pattern", pattern, DEF_PAT);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_tout", 64'(tout), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_tail", 64'(tail_cnt), 64'h0);
    rst_n = 1'b1;
    ser = 1'b1;

    // 1: no detect -> four send windows then timeout; held request does not restart
    start_seq(k);
    push_send_windows(k);
    push_ev(EV_TOUT, k + 801);
    mid_change(k);
    goto(k + 101);  chk("t1_busy_send", 64'(busy), 64'h1);
    goto(k + 802);  chk("t1_busy_after_tout", 64'(busy), 64'h0);
    goto(k + 830);  chk("t1_no_restart", 64'(busy), 64'h0);
    expect_drained("t1_drained");
    $display("txn t1 timeout run done at cyc=%0d", cyc_cnt);

    // 2: detect in GAP at d=150 -> TAIL at 151, four words, done after the 4th
    start_seq(k);
    push_valids(k + 2, k + 101);
    push_valids(k + 152, k + 155);
    push_ev(EV_DONE, k + 156);
    mid_change(k);
    goto(k + 150);  samp = 1'b1;
    goto(k + 151);  samp = 1'b0;
    goto(k + 153);  chk("t2_tail_2", 64'(tail_cnt), 64'h2);
    goto(k + 156);  chk("t2_tail_4", 64'(tail_cnt), 64'h4);
    goto(k + 160);  chk("t2_idle", 64'(busy), 64'h0);
                    chk("t2_tail_clr", 64'(tail_cnt), 64'h0);
    goto(k + 900);  expect_drained("t2_drained");
    $display("txn t2 gap detect done at cyc=%0d", cyc_cnt);

    // 3: detect in SEND at d=50, ser_done 3-low/3-high from d=51
    start_seq(k);
    push_valids(k + 2, k + 51);
    push_ev(EV_VALID, k + 55);
    push_ev(EV_VALID, k + 56);
    push_ev(EV_VALID, k + 57);
    push_ev(EV_VALID, k + 61);
    push_ev(EV_DONE, k + 62);
    mid_change(k);
    goto(k + 50);  samp = 1'b1;
    goto(k + 51);  samp = 1'b0;
    for (int d = 51; d <= 70; d++) begin
      goto(k + d);
      ser = (((d - 51) / 3) % 2) == 1;
      if (d == 56) chk("t3_tail_2", 64'(tail_cnt), 64'h2);
      if (d == 61) chk("t3_tail_4", 64'(tail_cnt), 64'h4);
      if (d == 63) chk("t3_tail_clr", 64'(tail_cnt), 64'h0);
    end
    ser = 1'b1;
    goto(k + 900);  expect_drained("t3_drained");
    $display("txn t3 send detect done at cyc=%0d", cyc_cnt);

    // 4: detect coincident with final timeout wrap at d=800 -> done, never timeout
    start_seq(k);
    push_send_windows(k);
    push_valids(k + 802, k + 805);
    push_ev(EV_DONE, k + 806);
    mid_change(k);
    goto(k + 800);  samp = 1'b1;
    goto(k + 801);  samp = 1'b0;
    goto(k + 805);  chk("t4_tail_4", 64'(tail_cnt), 64'h4);
    goto(k + 810);  chk("t4_idle", 64'(busy), 64'h0);
    goto(k + 850);  expect_drained("t4_drained");
    $display("txn t4 samp-vs-timeout done at cyc=%0d", cyc_cnt);

    // 5: abort in TAIL after two words, then a fresh request runs a full timeout
    start_seq(k);
    push_valids(k + 2, k + 101);
    push_ev(EV_VALID, k + 152);
    push_ev(EV_VALID, k + 153);
    mid_change(k);
    goto(k + 150);  samp = 1'b1;
    goto(k + 151);  samp = 1'b0;
    goto(k + 154);  abort = 1'b1;
    #1;             chk("t5_valid_masked", 64'(valid), 64'h0);
    goto(k + 155);  abort = 1'b0;
                    chk("t5_idle", 64'(busy), 64'h0);
                    chk("t5_tail_clr", 64'(tail_cnt), 64'h0);
    goto(k + 200);  expect_drained("t5_drained");
    start_seq(k);
    push_send_windows(k);
    push_ev(EV_TOUT, k + 801);
    goto(k + 802);  chk("t5_restart_idle", 64'(busy), 64'h0);
    expect_drained("t5_restart_drained");
    $display("txn t5 abort/restart done at cyc=%0d", cyc_cnt);

    // 6: asynchronous reset mid-SEND
    start_seq(k);
    push_valids(k + 2, k + 19);
    goto(k + 20);
    #2;
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk("t6_busy_rst", 64'(busy), 64'h0);
    chk("t6_valid_rst", 64'(valid), 64'h0);
    chk("t6_pattern_rst", pattern, DEF_PAT);
    goto(k + 22);  rst_n = 1'b1;
    goto(k + 30);  chk("t6_idle", 64'(busy), 64'h0);
    expect_drained("t6_drained");
    $display("txn t6 async reset done at cyc=%0d", cyc_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sb_pattern_gen_param.md
Name: sb_pattern_gen_param

Overview:
- Parametrised sideband clock-pattern generator for the LTSM SBINIT step.
- On request from the LTSM it bursts pattern words to the SB serializer in alternating 1 ms send / 1 ms gap windows.
- After the local RX reports pattern detection, it sends EXTRA_ITER more words, then pulses done to the LTSM.
- If TIMEOUT_MS elapses first, it pulses timeout instead.

Parameters:
- PATTERN_W, 64, pattern word width in bits; must be even.
- CYCLES_PER_MS, 100, i_clk cycles per 1 ms window; must be >= 2.
- TIMEOUT_MS, 8, number of ms windows (send and gap combined) before timeout; must be >= 2.
- EXTRA_ITER, 4, words sent after i_rx_sb_pattern_samp_done; must be >= 1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_start_pattern_req  in  1  level from LTSM; rising edge starts a sequence
- i_abort  in  1  synchronous abort; returns block to IDLE
- i_rx_sb_pattern_samp_done  in  1  pulse from local SB RX: pattern detected
- i_ser_done  in  1  serializer ready for next word
- o_pattern  out  PATTERN_W  pattern word
- o_pattern_valid  out  1  one-cycle qualifier for o_pattern
- o_start_pattern_done  out  1  one-cycle pulse: tail complete
- o_pattern_time_out  out  1  one-cycle pulse: timeout
- o_busy  out  1  high in any state other than IDLE
- o_tail_cnt  out  $clog2(EXTRA_ITER+1)  tail words sent so far (debug)

Behaviour:
- Reset values:
  - All outputs 0.
  - o_pattern = {PATTERN_W/2{2'b10}}.
  - FSM in IDLE; all counters 0; samp flag 0.
- FSM states: IDLE, SEND, GAP, TAIL, DONE, TOUT.
- IDLE:
  - On a rising edge of i_start_pattern_req, go to SEND.
  - ms_cyc and ms_cnt clear to 0.
  - A level held high does not restart the sequence after it ends.
- ms_cyc counter:
  - Counts 0..CYCLES_PER_MS-1 in SEND and GAP, then wraps to 0.
  - On each wrap, ms_cnt increments.
- SEND:
  - Each cycle with i_ser_done=1: o_pattern_valid=1 on the next cycle for exactly one cycle.
  - o_pattern is stable while valid.
  - On ms wrap: go to GAP.
- GAP:
  - No valid is generated; i_ser_done is ignored.
  - On ms wrap: go to SEND.
- Timeout:
  - In SEND or GAP, if ms wrap occurs with ms_cnt==TIMEOUT_MS-1, go to TOUT instead of toggling.
  - Timeout has priority over the SEND/GAP toggle.
- Samp flag:
  - i_rx_sb_pattern_samp_done in SEND or GAP sets a sticky samp flag.
  - Pulses in IDLE, DONE or TOUT are ignored.
- Leaving SEND/GAP on samp flag:
  - Samp flag set in SEND: go to TAIL on the cycle after the flag is set.
  - Samp flag set in GAP: go to TAIL immediately.
  - Samp flag and timeout wrap in the same cycle: samp wins, go to TAIL.
- TAIL:
  - ms counters frozen; timeout not checked.
  - Each i_ser_done emits one word and increments o_tail_cnt.
  - When o_tail_cnt reaches EXTRA_ITER (same cycle as the last valid), go to DONE.
- DONE: o_start_pattern_done=1 for one cycle; clear counters and samp flag; go to IDLE.
- TOUT: o_pattern_time_out=1 for one cycle; clear counters and samp flag; go to IDLE.
- i_abort:
  - In any state, next state is IDLE.
  - o_pattern_valid is forced 0 the same cycle.
  - No done or timeout pulse is issued.
  - Abort has priority over all other events.
- Latency: request edge to first valid is 2 cycles when i_ser_done is held high.
- Reset mid-operation: asynchronous return to reset values.

Optional Feature:
- Macro: SB_PATTERN_PROG_EN.
- Defined:
  - Adds port i_pattern (in, PATTERN_W).
  - i_pattern is captured into a register on the IDLE->SEND transition.
  - o_pattern drives the captured value for the whole sequence.
  - A change on i_pattern mid-sequence is ignored.
- Undefined: o_pattern is the constant {PATTERN_W/2{2'b10}}; no i_pattern port.

Test Plan:
- Defaults, i_ser_done=1, req rising at cycle 0, no samp: 100 valids in ms0, 0 in ms1, alternating; o_pattern_time_out pulses once at cycle 802 ± 1; o_busy falls after the pulse.
- Samp pulse at cycle 150 (GAP), i_ser_done=1: TAIL entered at cycle 151; exactly 4 valids; o_start_pattern_done pulses one cycle after the 4th valid; no timeout.
- Samp pulse in SEND with i_ser_done toggling every 3 cycles: exactly 4 tail words; o_tail_cnt reaches 4; done pulses once.
- Samp pulse coincident with the final timeout wrap: done is issued, timeout is never asserted.
- i_abort asserted in TAIL after 2 words: o_pattern_valid is 0 the same cycle, back in IDLE, no done/timeout; a new req edge restarts with ms_cnt=0.
- SB_PATTERN_PROG_EN defined, i_pattern=0xDEADBEEF_01234567 at start then changed: every valid carries 0xDEADBEEF_01234567. Run also with PATTERN_W=32, CYCLES_PER_MS=10, TIMEOUT_MS=4: timeout at cycle ~42.
